// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-stage program counter and flow control.
// Resolves ret/call/jmp/jiz, drives the return stack and inserts one flush
// bubble after each taken transfer and after reset.
// Optional feature: define STACK_CHK_EN to track return-stack depth,
// suppress overflowing pushes / underflowing pops and raise a sticky err.
module pc_ctrl #(
    parameter int NADDR  = 10,
    parameter int SDEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             jmp,
    input  logic             jiz,
    input  logic             zf,
    input  logic             call,
    input  logic             ret,
    input  logic [NADDR-1:0] addr,
    input  logic [NADDR-1:0] stk_top,
    output logic [NADDR-1:0] pc,
    output logic             flush,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [NADDR-1:0] stk_data,
    output logic             err
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [NADDR-1:0] pc_ex;
    logic [NADDR-1:0] pc_nxt;
    logic [NADDR-1:0] ret_addr;
    logic             decode;
    logic             do_ret;
    logic             do_call;
    logic             do_jmp;
    logic             do_jiz;
    logic             taken;
    logic             push_ok;
    logic             pop_ok;

`ifdef STACK_CHK_EN
    localparam int DW = $clog2(SDEPTH + 1);

    logic [DW-1:0] depth;
    logic          err_set;

    // Depth limits decide whether a decoded push/pop may actually be issued
    always_comb begin
        push_ok = (depth != DW'(SDEPTH));
        pop_ok  = (depth != '0);
        err_set = (do_call && !push_ok) || (do_ret && !pop_ok);
    end

    // Track the number of live return-stack entries from issued push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth <= '0;
        end else if (stk_push) begin
            depth <= depth + DW'(1);
        end else if (stk_pop) begin
            depth <= depth - DW'(1);
        end
    end

    // Sticky over/underflow flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end
`else
    // Without depth checking every decoded push/pop is issued as-is
    always_comb begin
        push_ok = (SDEPTH > 0);
        pop_ok  = (SDEPTH > 0);
    end

    assign err = 1'b0;
`endif

    // Decode strobes by priority ret > call > jmp > jiz, only in RUN when enabled
    always_comb begin
        decode   = (state == RUN) && en && !rst;
        do_ret   = decode && ret;
        do_call  = decode && !ret && call;
        do_jmp   = decode && !ret && !call && jmp;
        do_jiz   = decode && !ret && !call && !jmp && jiz && zf;
        taken    = do_ret || do_call || do_jmp || do_jiz;
        stk_push = do_call && push_ok;
        stk_pop  = do_ret && pop_ok;
        stk_data = pc_ex + NADDR'(1);
        flush    = (state != RUN);
        ret_addr = pop_ok ? stk_top : (pc_ex + NADDR'(1));
    end

    // Next state and next fetch address; applied only on enabled edges
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc + NADDR'(1);
        case (state)
            BOOT:    state_nxt = BUBBLE;
            BUBBLE:  state_nxt = RUN;
            RUN:     state_nxt = taken ? BUBBLE : RUN;
            default: state_nxt = BOOT;
        endcase
        if (do_ret) begin
            pc_nxt = ret_addr;
        end else if (do_call || do_jmp || do_jiz) begin
            pc_nxt = addr;
        end
    end

    // State, fetch address and decode address registers; frozen while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc    <= '0;
            pc_ex <= '0;
        end else if (en) begin
            state <= state_nxt;
            pc    <= pc_nxt;
            pc_ex <= pc;
        end
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: self-checking bench for pc_ctrl with a cycle-level reference model.
module tb_pc_ctrl;

`ifdef STACK_CHK_EN
    localparam bit CHK = 1'b1;
    localparam int SD  = 2;
`else
    localparam bit CHK = 1'b0;
    localparam int SD  = 8;
`endif

    localparam logic [23:0] RST_VEC = {10'h000, 1'b1, 1'b0, 1'b0, 10'h001, 1'b0};

    logic       clk = 1'b0;
    logic       rst;
    logic       en, jmp, jiz, zf, call, ret;
    logic [9:0] addr, stk_top;
    logic [9:0] pc, stk_data;
    logic       flush, stk_push, stk_pop, err;
    logic [23:0] obs;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [9:0] m_pc, m_pc_ex;
    int         m_bub;
    int         m_depth;
    logic       m_err;

    pc_ctrl #(.NADDR(10), .SDEPTH(SD)) dut (
        .clk(clk), .rst(rst), .en(en), .jmp(jmp), .jiz(jiz), .zf(zf),
        .call(call), .ret(ret), .addr(addr), .stk_top(stk_top),
        .pc(pc), .flush(flush), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_data(stk_data), .err(err)
    );

    assign obs = {pc, flush, stk_push, stk_pop, stk_data, err};

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic apply(input logic e, input logic j, input logic jz, input logic f,
                         input logic c, input logic r, input logic [9:0] a, input logic [9:0] t);
        en = e; jmp = j; jiz = jz; zf = f; call = c; ret = r; addr = a; stk_top = t;
    endtask

    task automatic model_reset();
        m_pc = '0; m_pc_ex = '0; m_bub = 2; m_depth = 0; m_err = 1'b0;
    endtask

    // 0 none, 1 return, 2 call, 3 jump, 4 taken jiz
    function automatic int kind();
        if (ret) return 1;
        if (call) return 2;
        if (jmp) return 3;
        if (jiz && zf) return 4;
        return 0;
    endfunction

    function automatic logic [23:0] model_vec();
        logic act, push, pop;
        logic [9:0] d;
        int k;
        act  = en && !rst && (m_bub == 0);
        k    = kind();
        push = act && (k == 2) && (!CHK || m_depth < SD);
        pop  = act && (k == 1) && (!CHK || m_depth > 0);
        d    = m_pc_ex + 10'd1;
        return {m_pc, (m_bub > 0), push, pop, d, m_err};
    endfunction

    task automatic model_edge();
        int k;
        logic [9:0] tgt;
        if (rst || !en) return;
        k   = (m_bub == 0) ? kind() : 0;
        tgt = addr;
        if (k == 1) begin
            if (CHK && m_depth == 0) begin
                m_err = 1'b1;
                tgt   = m_pc_ex + 10'd1;
            end else begin
                tgt = stk_top;
                if (CHK) m_depth--;
            end
        end else if (k == 2 && CHK) begin
            if (m_depth == SD) m_err = 1'b1;
            else m_depth++;
        end
        m_pc_ex = m_pc;
        if (k != 0) begin
            m_pc  = tgt;
            m_bub = 1;
        end else begin
            m_pc  = m_pc + 10'd1;
            if (m_bub > 0) m_bub--;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 10'h0, 10'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(1, 1, 1, 1, 1, 1, 10'h155, 10'h0AA);
        #2;
        checks++;
        if (obs !== RST_VEC) begin
            errors++;
            $display("[TB] FAIL reset_async: got %h expected %h", obs, RST_VEC);
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== RST_VEC) begin
            errors++;
            $display("[TB] FAIL reset_hold: got %h expected %h", obs, RST_VEC);
        end
        model_reset();
        rst = 1'b0;
        apply(1, 0, 0, 0, 0, 0, 10'h0, 10'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("[TB] FAIL reset_seq cycle %0d: got %h expected %h", i, obs, model_vec());
            end
            checks++;
            if (flush !== (i < 2)) begin
                errors++;
                $display("[TB] FAIL reset_flush cycle %0d: got %b expected %b", i, flush, (i < 2));
            end
            step();
        end
    endtask

    task automatic test_wrap();
        logic saw_wrap = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) apply(1, 1, 0, 0, 0, 0, 10'h3FD, 10'h0);
            else        apply(1, 0, 0, 0, 0, 0, 10'h0, 10'h0);
            @(negedge clk);
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("[TB] FAIL wrap cycle %0d: got %h expected %h", i, obs, model_vec());
            end
            if (i == 4 && pc === 10'h000) saw_wrap = 1'b1;
            step();
        end
        checks++;
        if (saw_wrap !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_zero: got %b expected 1", saw_wrap);
        end
    endtask

    task automatic test_call_ret();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       apply(1, 1, 0, 0, 0, 0, 10'h010, 10'h0);
                2:       apply(1, 0, 0, 0, 1, 0, 10'h040, 10'h0);
                5:       apply(1, 0, 0, 0, 0, 1, 10'h0, 10'h011);
                default: apply(1, 0, 0, 0, 0, 0, 10'h0, 10'h011);
            endcase
            @(negedge clk);
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("[TB] FAIL call_ret cycle %0d: got %h expected %h", i, obs, model_vec());
            end
            if (i == 2) begin
                checks++;
                if ({stk_push, stk_data} !== {1'b1, 10'h011}) begin
                    errors++;
                    $display("[TB] FAIL call_push: got %b/%h expected 1/011", stk_push, stk_data);
                end
            end
            if (i == 3 || i == 6) begin
                checks++;
                if ({pc, flush} !== {(i == 3) ? 10'h040 : 10'h011, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL call_ret_target cycle %0d: got %h/%b", i, pc, flush);
                end
            end
            if (i == 5) begin
                checks++;
                if (stk_pop !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL ret_pop: got %b expected 1", stk_pop);
                end
            end
            step();
        end
    endtask

    task automatic test_jiz();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       apply(1, 0, 1, 0, 0, 0, 10'h100, 10'h0);
                2:       apply(1, 0, 1, 1, 0, 0, 10'h100, 10'h0);
                default: apply(1, 0, 0, 0, 0, 0, 10'h0, 10'h0);
            endcase
            @(negedge clk);
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("[TB] FAIL jiz cycle %0d: got %h expected %h", i, obs, model_vec());
            end
            if (i == 1) begin
                checks++;
                if (flush !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL jiz_notaken_flush: got %b expected 0", flush);
                end
            end
            if (i == 3) begin
                checks++;
                if ({pc, flush} !== {10'h100, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL jiz_taken: got %h/%b expected 100/1", pc, flush);
                end
            end
            step();
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       apply(1, 0, 0, 0, 1, 0, 10'h050, 10'h0);
                2:       apply(1, 1, 1, 1, 1, 1, 10'h333, 10'h1AB);
                default: apply(1, 0, 0, 0, 0, 0, 10'h0, 10'h1AB);
            endcase
            @(negedge clk);
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("[TB] FAIL priority cycle %0d: got %h expected %h", i, obs, model_vec());
            end
            if (i == 2) begin
                checks++;
                if ({stk_push, stk_pop} !== 2'b01) begin
                    errors++;
                    $display("[TB] FAIL priority_pop: got %b%b expected 01", stk_push, stk_pop);
                end
            end
            if (i == 3) begin
                checks++;
                if (pc !== 10'h1AB) begin
                    errors++;
                    $display("[TB] FAIL priority_pc: got %h expected 1ab", pc);
                end
            end
            step();
        end
    endtask

    task automatic test_stall();
        int pushes = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 3)       apply(0, 0, 0, 0, 1, 0, 10'h200, 10'h0);
            else if (i == 3) apply(1, 0, 0, 0, 1, 0, 10'h200, 10'h0);
            else             apply(1, 0, 0, 0, 0, 0, 10'h0, 10'h0);
            @(negedge clk);
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("[TB] FAIL stall cycle %0d: got %h expected %h", i, obs, model_vec());
            end
            if (stk_push === 1'b1) pushes++;
            if (i == 4) begin
                checks++;
                if ({pc, flush} !== {10'h200, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL stall_target: got %h/%b expected 200/1", pc, flush);
                end
            end
            step();
        end
        checks++;
        if (pushes != 1) begin
            errors++;
            $display("[TB] FAIL stall_push_count: got %0d expected 1", pushes);
        end
        // reset asserted while stalled with a strobe pending
        apply(0, 1, 0, 0, 0, 1, 10'h2AA, 10'h155);
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== RST_VEC) begin
            errors++;
            $display("[TB] FAIL reset_mid_stall: got %h expected %h", obs, RST_VEC);
        end
        model_reset();
        apply(0, 0, 0, 0, 0, 0, 10'h0, 10'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            apply(1, 1, 0, 0, 0, 0, 10'($urandom), 10'h0);
            @(negedge clk);
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("[TB] FAIL back_to_back cycle %0d: got %h expected %h", i, obs, model_vec());
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0, 1'($urandom), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0, 10'($urandom), 10'($urandom));
            @(negedge clk);
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got %h expected %h", i, obs, model_vec());
            end
            step();
        end
    endtask

    task automatic test_stack_chk();
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            if (i == 2 || i == 4 || i == 6) apply(1, 0, 0, 0, 1, 0, 10'(i * 64), 10'h0);
            else                            apply(1, 0, 0, 0, 0, 0, 10'h0, 10'h0);
            @(negedge clk);
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("[TB] FAIL nested_call cycle %0d: got %h expected %h", i, obs, model_vec());
            end
            if (i == 6) begin
                checks++;
                if (stk_push !== !CHK) begin
                    errors++;
                    $display("[TB] FAIL third_push: got %b expected %b", stk_push, !CHK);
                end
            end
            if (i == 8) begin
                checks++;
                if ({pc, err} !== {10'h181, CHK}) begin
                    errors++;
                    $display("[TB] FAIL overflow_err: got %h/%b expected 181/%b", pc, err, CHK);
                end
            end
            step();
        end
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 2) apply(1, 0, 0, 0, 0, 1, 10'h0, 10'h3C3);
            else        apply(1, 0, 0, 0, 0, 0, 10'h0, 10'h3C3);
            @(negedge clk);
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("[TB] FAIL underflow cycle %0d: got %h expected %h", i, obs, model_vec());
            end
            if (i == 2) begin
                checks++;
                if (stk_pop !== !CHK) begin
                    errors++;
                    $display("[TB] FAIL underflow_pop: got %b expected %b", stk_pop, !CHK);
                end
            end
            if (i == 3) begin
                checks++;
                if ({pc, flush} !== {CHK ? 10'h002 : 10'h3C3, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL underflow_pc: got %h/%b", pc, flush);
                end
            end
            if (i == 7) begin
                checks++;
                if (err !== CHK) begin
                    errors++;
                    $display("[TB] FAIL err_sticky: got %b expected %b", err, CHK);
                end
            end
            step();
        end
        pulse_reset();
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_cleared: got %b expected 0", err);
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 10'h0, 10'h0);
        model_reset();
        #1;
        test_reset();
        test_wrap();
        test_call_ret();
        test_jiz();
        test_priority();
        test_stall();
        test_back_to_back();
        test_random();
        test_stack_chk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter and flow-control unit of the processor fetch stage, directly upstream of the subroutine return stack. Generates the instruction-memory address each cycle and resolves jumps, conditional jumps, calls and returns from decoder strobes. Drives the return stack's push/pop/in ports and consumes its registered top-of-stack output. Inserts a one-cycle flush bubble after every taken transfer and after reset.

## Interface
- NADDR, 10, PC and return-address width.
- SDEPTH, 8, return-stack depth in entries. Used only for depth checking.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  advance enable. 0 = stall: all state frozen, stk_push/stk_pop low.
- jmp  in  1  unconditional jump strobe.
- jiz  in  1  jump-if-zero strobe.
- zf  in  1  zero flag, qualifies jiz.
- call  in  1  subroutine call strobe.
- ret  in  1  subroutine return strobe.
- addr  in  NADDR  target for jmp/jiz/call.
- stk_top  in  NADDR  registered top of the return stack.
- pc  out  NADDR  fetch address (registered).
- flush  out  1  the instruction now being decoded is invalid.
- stk_push  out  1  return-stack push.
- stk_pop  out  1  return-stack pop.
- stk_data  out  NADDR  return address, pc_ex+1 mod 2^NADDR.
- err  out  1  sticky stack over/underflow flag.

## Operation
- Internal pc_ex is the address of the instruction in decode: instruction memory has 1-cycle read latency, so pc_ex <= pc on every enabled edge.
- States: BOOT (after reset), RUN, BUBBLE. flush = (state != RUN).
- BOOT --en--> BUBBLE --en--> RUN. RUN --taken transfer & en--> BUBBLE. Otherwise RUN stays in RUN.
- Control inputs are evaluated only in RUN with en=1. They are ignored in BOOT and BUBBLE.
- Priority: ret > call > jmp > jiz. Lower-priority strobes in the same cycle are ignored.
- ret: stk_pop=1, pc <= stk_top, taken.
- call: stk_push=1, stk_data=pc_ex+1, pc <= addr, taken.
- jmp: pc <= addr, taken.
- jiz: taken only if zf=1, with pc <= addr. If zf=0, it is a plain increment.
- No transfer: pc <= pc+1, wrapping 2^NADDR-1 -> 0.
- stk_push and stk_pop are combinational from strobes, state and en. They are never both high.
- The stack output is stale for one cycle after a push. The mandatory BUBBLE after call guarantees stk_top is valid at the earliest possible ret.

## Timing
- Reset values: pc=0, pc_ex=0, state=BOOT, flush=1, stk_push=0, stk_pop=0, stk_data=1, err=0.
- Taken transfer decoded in cycle t: pc = target in t+1, flush=1 in t+1, pc_ex = target in t+2, flush=0 in t+2.
- Transfer penalty is exactly 1 cycle. Sequential throughput is 1 instruction/cycle.
- Stall (en=0) for N cycles delays every transition above by exactly N cycles and never drops a strobe. The decoder holds strobes during stalls.
- Asserting rst mid-transfer or mid-stall returns all registers to reset values immediately. No push/pop is issued while rst is high.

## Configuration
- STACK_CHK_EN defined:
  - An internal depth counter (0..SDEPTH) increments on an issued push and decrements on an issued pop.
  - call at depth SDEPTH: push suppressed, err <= 1, jump still taken.
  - ret at depth 0: pop suppressed, err <= 1, pc <= pc_ex+1, treated as taken (bubble).
  - err is cleared only by rst.
- STACK_CHK_EN undefined: no counter, err tied 0, push/pop always issued as decoded.

## Test plan
- Reset, en=1, no strobes -> flush=1 for 2 cycles, then pc 0,1,2,... and pc_ex lags pc by one. pc=2^NADDR-1 wraps to 0.
- call addr=0x040 at pc_ex=0x010 -> stk_push=1 and stk_data=0x011 that cycle, pc=0x040 next, one flush cycle. A later ret with stk_top=0x011 -> stk_pop=1, pc=0x011, one flush cycle.
- jiz addr=0x100: zf=0 -> pc increments with no flush. zf=1 -> pc=0x100 with one flush cycle.
- ret+call+jmp asserted together -> only the pop is issued and pc=stk_top.
- en=0 held for 3 cycles during a call -> no push while stalled. Push issued exactly once when en returns, pc and flush sequence shifted by 3 cycles.
- STACK_CHK_EN, SDEPTH=2:
  - three nested calls -> third push suppressed, err=1.
  - ret from depth 0 after reset -> no pop, pc=pc_ex+1, err=1.
  - err stays 1 until rst.
